// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package ifu_fetch_pkg;

    localparam int          CPU_WIDTH    = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
    localparam logic [31:0] INS_NOP      = 32'h0000_0013;

    typedef enum logic [2:0] {
        IFU_ST_BOOT = 3'd0,
        IFU_ST_REQ  = 3'd1,
        IFU_ST_WAIT = 3'd2,
        IFU_ST_HOLD = 3'd3,
        IFU_ST_ERR  = 3'd4
    } ifu_state_e;

    // Instruction targets must be word aligned.
    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return low_bits != 2'b00;
    endfunction

endpackage

// File: rtl/ifu_pc.sv
// Architectural PC register with hold / +4 / redirect next-PC selection.
// Redirect wins over advance; the caller only asserts redirect for an
// aligned target in a state where redirects are honoured.
module ifu_pc
    import ifu_fetch_pkg::*;
#(
    parameter int               CPU_W    = CPU_WIDTH,
    parameter logic [CPU_W-1:0] RESET_PC = CPU_W'(RESET_PC_DEF)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             redirect,
    input  logic [CPU_W-1:0] redirect_pc,
    input  logic             advance,
    output logic [CPU_W-1:0] pc,
    output logic             misaligned
);

    assign misaligned = is_misaligned(redirect_pc[1:0]);

    // PC update: redirect target, sequential +4 (wraps at 2^CPU_W), or hold.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= redirect_pc;
        end else if (advance) begin
            pc <= pc + CPU_W'(4);
        end
    end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: one outstanding word fetch, output register
// toward decode, redirect handling with wrong-path response dropping.
//
// state | meaning
// BOOT  | first cycle after reset, no request
// REQ   | request valid at PC, waiting for memory ready
// WAIT  | request accepted, waiting for the single response
// HOLD  | instruction presented to decode, waiting for consume
// ERR   | misaligned redirect seen, stalled until reset
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter int               CPU_W    = CPU_WIDTH,
    parameter logic [CPU_W-1:0] RESET_PC = CPU_W'(RESET_PC_DEF)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_redirect,
    input  logic [CPU_W-1:0] i_redirect_pc,
    output logic             o_imem_req_valid,
    input  logic             i_imem_req_ready,
    output logic [CPU_W-1:0] o_imem_addr,
    input  logic             i_imem_rsp_valid,
    input  logic [31:0]      i_imem_rsp_data,
    output logic             o_ins_valid,
    input  logic             i_ins_ready,
    output logic [31:0]      o_ins,
    output logic [CPU_W-1:0] o_ins_pc,
    output logic             o_fetch_err
);

    ifu_state_e       state;
    ifu_state_e       state_next;
    logic [CPU_W-1:0] pc;
    logic             misaligned;
    logic             redirect_ok;
    logic             redirect_bad;
    logic             pc_redirect;
    logic             pc_advance;
    logic             capture;
    logic             clr_valid;
    logic             set_err;
    logic             drop;
    logic             drop_set;
    logic             drop_clr;

    ifu_pc #(
        .CPU_W    (CPU_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .redirect    (pc_redirect),
        .redirect_pc (i_redirect_pc),
        .advance     (pc_advance),
        .pc          (pc),
        .misaligned  (misaligned)
    );

    assign o_imem_addr  = pc;
    assign redirect_ok  = i_redirect && !misaligned;
    assign redirect_bad = i_redirect && misaligned;

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IFU_ST_BOOT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control decode; a redirect in REQ withdraws the request.
    always_comb begin
        state_next       = state;
        o_imem_req_valid = 1'b0;
        pc_redirect      = 1'b0;
        pc_advance       = 1'b0;
        capture          = 1'b0;
        clr_valid        = 1'b0;
        set_err          = 1'b0;
        drop_set         = 1'b0;
        drop_clr         = 1'b0;
        unique case (state)
            IFU_ST_BOOT: begin
                state_next = IFU_ST_REQ;
            end
            IFU_ST_REQ: begin
                if (redirect_bad) begin
                    set_err    = 1'b1;
                    state_next = IFU_ST_ERR;
                end else if (redirect_ok) begin
                    pc_redirect = 1'b1;
                end else begin
                    o_imem_req_valid = 1'b1;
                    if (i_imem_req_ready) begin
                        state_next = IFU_ST_WAIT;
                    end
                end
            end
            IFU_ST_WAIT: begin
                if (redirect_bad) begin
                    set_err    = 1'b1;
                    state_next = IFU_ST_ERR;
                end else if (redirect_ok) begin
                    pc_redirect = 1'b1;
                    if (i_imem_rsp_valid) begin
                        drop_clr   = 1'b1;
                        state_next = IFU_ST_REQ;
                    end else begin
                        drop_set = 1'b1;
                    end
                end else if (i_imem_rsp_valid) begin
                    if (drop) begin
                        drop_clr   = 1'b1;
                        state_next = IFU_ST_REQ;
                    end else begin
                        capture    = 1'b1;
                        state_next = IFU_ST_HOLD;
                    end
                end
            end
            IFU_ST_HOLD: begin
                if (redirect_bad) begin
                    set_err    = 1'b1;
                    state_next = IFU_ST_ERR;
                end else if (redirect_ok) begin
                    pc_redirect = 1'b1;
                    clr_valid   = 1'b1;
                    state_next  = IFU_ST_REQ;
                end else if (i_ins_ready) begin
                    pc_advance = 1'b1;
                    clr_valid  = 1'b1;
                    state_next = IFU_ST_REQ;
                end
            end
            IFU_ST_ERR: begin
                state_next = IFU_ST_ERR;
            end
            default: begin
                state_next = IFU_ST_ERR;
            end
        endcase
    end

    // Output register toward decode, sticky error and wrong-path drop flag.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_ins       <= INS_NOP;
            o_ins_pc    <= RESET_PC;
            o_ins_valid <= 1'b0;
            o_fetch_err <= 1'b0;
            drop        <= 1'b0;
        end else begin
            if (capture) begin
                o_ins    <= i_imem_rsp_data;
                o_ins_pc <= pc;
            end
            if (set_err) begin
                o_fetch_err <= 1'b1;
                o_ins_valid <= 1'b0;
            end else if (capture) begin
                o_ins_valid <= 1'b1;
            end else if (clr_valid) begin
                o_ins_valid <= 1'b0;
            end
            if (drop_set) begin
                drop <= 1'b1;
            end else if (drop_clr) begin
                drop <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed-vector bench for ifu_fetch. Each vector drives all inputs for
// one cycle and lists the outputs expected during that cycle.
module tb_ifu_fetch;

    localparam logic [31:0] A0  = 32'h8000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic        req_ready;
        logic        rsp_valid;
        logic [31:0] rsp_data;
        logic        ins_ready;
        logic        redirect;
        logic [31:0] redirect_pc;
        logic        e_req_valid;
        logic [31:0] e_addr;
        logic        e_ins_valid;
        logic [31:0] e_ins;
        logic [31:0] e_ins_pc;
        logic        e_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic [31:0] addr;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data = 32'h0;
    logic        ins_valid;
    logic        ins_ready = 1'b0;
    logic [31:0] ins;
    logic [31:0] ins_pc;
    logic        fetch_err;

    int n_vec = 0;
    int n_bad = 0;

    vec_t main_tbl[10];

    ifu_fetch dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_redirect       (redirect),
        .i_redirect_pc    (redirect_pc),
        .o_imem_req_valid (req_valid),
        .i_imem_req_ready (req_ready),
        .o_imem_addr      (addr),
        .i_imem_rsp_valid (rsp_valid),
        .i_imem_rsp_data  (rsp_data),
        .o_ins_valid      (ins_valid),
        .i_ins_ready      (ins_ready),
        .o_ins            (ins),
        .o_ins_pc         (ins_pc),
        .o_fetch_err      (fetch_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, vectors=%0d", n_vec);
        $fatal(1);
    end

    function automatic vec_t v(
        input logic rr, input logic rv, input logic [31:0] rd,
        input logic ir, input logic re, input logic [31:0] rp,
        input logic erv, input logic [31:0] ea, input logic eiv,
        input logic [31:0] ei, input logic [31:0] ep, input logic ee);
        vec_t x;
        x.req_ready = rr;  x.rsp_valid = rv;  x.rsp_data = rd;
        x.ins_ready = ir;  x.redirect = re;   x.redirect_pc = rp;
        x.e_req_valid = erv; x.e_addr = ea;   x.e_ins_valid = eiv;
        x.e_ins = ei;      x.e_ins_pc = ep;   x.e_err = ee;
        return x;
    endfunction

    task automatic drive(input vec_t x);
        req_ready   = x.req_ready;
        rsp_valid   = x.rsp_valid;
        rsp_data    = x.rsp_data;
        ins_ready   = x.ins_ready;
        redirect    = x.redirect;
        redirect_pc = x.redirect_pc;
    endtask

    task automatic check(input vec_t x, input string tag);
        bit bad = 0;
        if (req_valid !== x.e_req_valid) begin
            $display("FAIL %s req_valid: got %0b want %0b", tag, req_valid, x.e_req_valid); bad = 1;
        end
        if (addr !== x.e_addr) begin
            $display("FAIL %s imem_addr: got %h want %h", tag, addr, x.e_addr); bad = 1;
        end
        if (ins_valid !== x.e_ins_valid) begin
            $display("FAIL %s ins_valid: got %0b want %0b", tag, ins_valid, x.e_ins_valid); bad = 1;
        end
        if (ins !== x.e_ins) begin
            $display("FAIL %s ins: got %h want %h", tag, ins, x.e_ins); bad = 1;
        end
        if (ins_pc !== x.e_ins_pc) begin
            $display("FAIL %s ins_pc: got %h want %h", tag, ins_pc, x.e_ins_pc); bad = 1;
        end
        if (fetch_err !== x.e_err) begin
            $display("FAIL %s fetch_err: got %0b want %0b", tag, fetch_err, x.e_err); bad = 1;
        end
        n_vec++;
        if (bad) n_bad++;
    endtask

    // One cycle: drive at the falling edge, compare just after it.
    task automatic apply(input vec_t x, input string tag);
        @(negedge clk);
        drive(x);
        #1;
        check(x, tag);
    endtask

    // Reset pulse, then one BOOT cycle during which a redirect is offered
    // and must be ignored.
    task automatic do_reset(input string tag);
        vec_t r;
        @(negedge clk);
        rst = 1'b1;
        r = v(0, 0, 32'h0, 0, 0, 32'h0, 0, A0, 0, NOP, A0, 0);
        drive(r);
        #1;
        check(r, {tag, "_in_reset"});
        @(negedge clk);
        rst = 1'b0;
        r = v(1, 0, 32'h0, 1, 1, 32'h8000_1000, 0, A0, 0, NOP, A0, 0);
        drive(r);
        #1;
        check(r, {tag, "_boot"});
    endtask

    initial begin
        //                 rr rv rsp_data      ir re redir_pc      erv e_addr        eiv e_ins          e_pc          err
        main_tbl[0] = v(1, 0, 32'h0,        1, 0, 32'h0,        1, A0,           0, NOP,           A0,           0);
        main_tbl[1] = v(1, 1, 32'h1111_0001, 1, 0, 32'h0,       0, A0,           0, NOP,           A0,           0);
        main_tbl[2] = v(1, 0, 32'h0,        1, 0, 32'h0,        0, A0,           1, 32'h1111_0001, A0,           0);
        main_tbl[3] = v(1, 0, 32'h0,        1, 0, 32'h0,        1, 32'h8000_0004, 0, 32'h1111_0001, A0,           0);
        main_tbl[4] = v(1, 1, 32'h2222_0002, 1, 0, 32'h0,       0, 32'h8000_0004, 0, 32'h1111_0001, A0,           0);
        main_tbl[5] = v(1, 0, 32'h0,        1, 0, 32'h0,        0, 32'h8000_0004, 1, 32'h2222_0002, 32'h8000_0004, 0);
        main_tbl[6] = v(1, 0, 32'h0,        1, 0, 32'h0,        1, 32'h8000_0008, 0, 32'h2222_0002, 32'h8000_0004, 0);
        main_tbl[7] = v(1, 1, 32'h3333_0003, 1, 0, 32'h0,       0, 32'h8000_0008, 0, 32'h2222_0002, 32'h8000_0004, 0);
        main_tbl[8] = v(1, 0, 32'h0,        1, 0, 32'h0,        0, 32'h8000_0008, 1, 32'h3333_0003, 32'h8000_0008, 0);
        main_tbl[9] = v(1, 0, 32'h0,        1, 0, 32'h0,        1, 32'h8000_000C, 0, 32'h3333_0003, 32'h8000_0008, 0);

        do_reset("rst0");
        for (int i = 0; i < 10; i++) begin
            apply(main_tbl[i], $sformatf("main[%0d]", i));
        end

        // Reset while a fetch is outstanding; a late response in REQ is ignored.
        do_reset("rst1");
        apply(v(0, 1, 32'hBAD0_0000, 0, 0, 32'h0, 1, A0, 0, NOP, A0, 0), "stall_req_stray");
        for (int i = 1; i < 4; i++) begin
            apply(v(0, 0, 32'h0, 0, 0, 32'h0, 1, A0, 0, NOP, A0, 0), $sformatf("stall_req[%0d]", i));
        end
        apply(v(1, 0, 32'h0, 0, 0, 32'h0, 1, A0, 0, NOP, A0, 0), "stall_req_accept");
        apply(v(0, 0, 32'h0, 0, 0, 32'h0, 0, A0, 0, NOP, A0, 0), "wait_idle");
        apply(v(0, 1, 32'h4444_0004, 0, 0, 32'h0, 0, A0, 0, NOP, A0, 0), "wait_rsp");
        for (int i = 0; i < 5; i++) begin
            apply(v(1, 0, 32'h0, 0, 0, 32'h0, 0, A0, 1, 32'h4444_0004, A0, 0), $sformatf("hold_stall[%0d]", i));
        end
        apply(v(0, 0, 32'h0, 1, 0, 32'h0, 0, A0, 1, 32'h4444_0004, A0, 0), "hold_consume");
        apply(v(0, 0, 32'h0, 0, 0, 32'h0, 1, 32'h8000_0004, 0, 32'h4444_0004, A0, 0), "pc_plus4");

        // Redirect while waiting: the late response is dropped.
        apply(v(1, 0, 32'h0, 0, 0, 32'h0, 1, 32'h8000_0004, 0, 32'h4444_0004, A0, 0), "wr_req");
        apply(v(0, 0, 32'h0, 0, 1, 32'h8000_0100, 0, 32'h8000_0004, 0, 32'h4444_0004, A0, 0), "wr_redirect");
        apply(v(0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h8000_0100, 0, 32'h4444_0004, A0, 0), "wr_wait");
        apply(v(0, 1, 32'hDEAD_BEEF, 1, 0, 32'h0, 0, 32'h8000_0100, 0, 32'h4444_0004, A0, 0), "wr_drop_rsp");
        apply(v(1, 0, 32'h0, 1, 0, 32'h0, 1, 32'h8000_0100, 0, 32'h4444_0004, A0, 0), "wr_refetch");
        apply(v(0, 1, 32'h5555_0005, 0, 0, 32'h0, 0, 32'h8000_0100, 0, 32'h4444_0004, A0, 0), "wr_rsp");
        apply(v(0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h8000_0100, 1, 32'h5555_0005, 32'h8000_0100, 0), "wr_hold");

        // Redirect in HOLD beats ins_ready.
        apply(v(0, 0, 32'h0, 1, 1, 32'h8000_0200, 0, 32'h8000_0100, 1, 32'h5555_0005, 32'h8000_0100, 0), "hr_redirect");
        apply(v(0, 0, 32'h0, 0, 0, 32'h0, 1, 32'h8000_0200, 0, 32'h5555_0005, 32'h8000_0100, 0), "hr_req");

        // Redirect in REQ withdraws the request even with ready high.
        apply(v(1, 0, 32'h0, 0, 1, 32'h8000_0300, 0, 32'h8000_0200, 0, 32'h5555_0005, 32'h8000_0100, 0), "rr_withdraw");
        apply(v(1, 0, 32'h0, 0, 0, 32'h0, 1, 32'h8000_0300, 0, 32'h5555_0005, 32'h8000_0100, 0), "rr_reissue");

        // Redirect coinciding with the response discards it at once.
        apply(v(0, 1, 32'h6666_0006, 0, 1, 32'h8000_0400, 0, 32'h8000_0300, 0, 32'h5555_0005, 32'h8000_0100, 0), "wc_redirect_rsp");
        apply(v(1, 0, 32'h0, 0, 0, 32'h0, 1, 32'h8000_0400, 0, 32'h5555_0005, 32'h8000_0100, 0), "wc_req");
        apply(v(0, 1, 32'h7777_0007, 0, 0, 32'h0, 0, 32'h8000_0400, 0, 32'h5555_0005, 32'h8000_0100, 0), "wc_rsp");
        apply(v(0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h8000_0400, 1, 32'h7777_0007, 32'h8000_0400, 0), "wc_hold");

        // Stray response in HOLD must not disturb the output register.
        apply(v(0, 1, 32'h9999_9999, 0, 0, 32'h0, 0, 32'h8000_0400, 1, 32'h7777_0007, 32'h8000_0400, 0), "hold_stray");
        apply(v(0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h8000_0400, 1, 32'h7777_0007, 32'h8000_0400, 0), "hold_after_stray");

        // Misaligned redirect: sticky error, PC held, no further requests.
        apply(v(1, 0, 32'h0, 1, 1, 32'h8000_0102, 0, 32'h8000_0400, 1, 32'h7777_0007, 32'h8000_0400, 0), "mis_redirect");
        apply(v(1, 0, 32'h0, 1, 0, 32'h0, 0, 32'h8000_0400, 0, 32'h7777_0007, 32'h8000_0400, 1), "err_0");
        apply(v(1, 1, 32'h1234_5678, 1, 1, 32'h8000_0500, 0, 32'h8000_0400, 0, 32'h7777_0007, 32'h8000_0400, 1), "err_1");
        apply(v(1, 0, 32'h0, 1, 0, 32'h0, 0, 32'h8000_0400, 0, 32'h7777_0007, 32'h8000_0400, 1), "err_2");

        // Restart after reset, then check PC wrap past 0xFFFF_FFFC.
        do_reset("rst2");
        apply(v(1, 0, 32'h0, 0, 0, 32'h0, 1, A0, 0, NOP, A0, 0), "rs_req");
        apply(v(0, 1, 32'h8888_0008, 0, 0, 32'h0, 0, A0, 0, NOP, A0, 0), "rs_rsp");
        apply(v(0, 0, 32'h0, 1, 1, 32'hFFFF_FFFC, 0, A0, 1, 32'h8888_0008, A0, 0), "wrap_redirect");
        apply(v(1, 0, 32'h0, 0, 0, 32'h0, 1, 32'hFFFF_FFFC, 0, 32'h8888_0008, A0, 0), "wrap_req");
        apply(v(0, 1, 32'hAAAA_000A, 0, 0, 32'h0, 0, 32'hFFFF_FFFC, 0, 32'h8888_0008, A0, 0), "wrap_rsp");
        apply(v(0, 0, 32'h0, 1, 0, 32'h0, 0, 32'hFFFF_FFFC, 1, 32'hAAAA_000A, 32'hFFFF_FFFC, 0), "wrap_consume");
        apply(v(0, 0, 32'h0, 0, 0, 32'h0, 1, 32'h0000_0000, 0, 32'hAAAA_000A, 32'hFFFF_FFFC, 0), "wrap_zero");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
